// File: rtl/key_debounce_pulse.sv
//-----------------------------------------------------------------------------
// key_debounce_pulse
//
// Conditions the two raw, active-low board buttons (KEY2, KEY0) for the
// push-button counter logic. Each button is synchronised to clk, debounced,
// and turned into exactly one single-cycle press pulse per physical press.
// A button that is held therefore counts once downstream, not once per clock.
// The two channels are identical and fully independent.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   rst         synchronous, active-high reset
//   key2_n      raw KEY2, active low, asynchronous to clk
//   key0_n      raw KEY0, active low, asynchronous to clk
//   key2_pulse  one-cycle pulse per debounced KEY2 press (drives Key_2)
//   key0_pulse  one-cycle pulse per debounced KEY0 press (drives Key_0)
//   key2_level  debounced KEY2 state, 1 = held
//   key0_level  debounced KEY0 state, 1 = held
//
// Parameters:
//   CNT_MAX  consecutive stable synchronised samples needed to accept a
//            press or a release (1_000_000 = 20 ms at 50 MHz), 2..2^CNT_W-1
//   CNT_W    debounce counter width, CNT_MAX-1 must fit
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

//-----------------------------------------------------------------------------
// key_debounce_channel
//
// One button channel: two-flop synchroniser followed by a four-state
// debounce FSM with registered pulse and level outputs.
//
// Ports:
//   clk      system clock
//   rst      synchronous, active-high reset
//   i_key_n  raw button, active low
//   o_pulse  one-cycle pulse on each accepted press
//   o_level  debounced button state, 1 = held
//-----------------------------------------------------------------------------
module key_debounce_channel #(
    parameter int CNT_MAX = 1000000,
    parameter int CNT_W   = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_pulse,
    output logic o_level
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    // Synchroniser flops; reset to 1 so the channel wakes up "released".
    logic r_sync1;
    logic r_sync2;
    logic w_s;          // synchronised button, 1 = pressed

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_pulse;
    logic             w_pulse_nxt;
    logic             r_level;
    logic             w_level_nxt;

    // The raw input feeds only the first flop; everything downstream sees
    // the second flop, so metastability has a full cycle to settle.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours; blocking here would collapse the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = ~r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_level <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pulse <= w_pulse_nxt;
            r_level <= w_level_nxt;
        end
    end

    // Pulse defaults to 0 every cycle, so it can only be high for the single
    // cycle following the PRESS_WAIT -> HELD transition.
    always_comb begin
        // NOTE: every output of this block is given a default first; a path
        // that leaves one unassigned would infer a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pulse_nxt = 1'b0;
        w_level_nxt = r_level;

        unique case (r_state)
            IDLE: begin
                if (w_s) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end

            PRESS_WAIT: begin
                if (!w_s) begin
                    w_state_nxt = IDLE;            // bounce: abandon the press
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = HELD;
                    w_pulse_nxt = 1'b1;
                    w_level_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            HELD: begin
                if (!w_s) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end
            end

            RELEASE_WAIT: begin
                if (w_s) begin
                    w_state_nxt = HELD;            // release glitch, no new pulse
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                    w_level_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_pulse = r_pulse;
    assign o_level = r_level;

endmodule

//-----------------------------------------------------------------------------
// Top level: two independent channels. Both pulses may be high in the same
// cycle; priority between them is resolved by the downstream counter.
//-----------------------------------------------------------------------------
module key_debounce_pulse #(
    parameter int CNT_MAX = 1000000,
    parameter int CNT_W   = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key2_n,
    input  logic key0_n,
    output logic key2_pulse,
    output logic key0_pulse,
    output logic key2_level,
    output logic key0_level
);

    key_debounce_channel #(
        .CNT_MAX (CNT_MAX),
        .CNT_W   (CNT_W)
    ) u_key2 (
        .clk     (clk),
        .rst     (rst),
        .i_key_n (key2_n),
        .o_pulse (key2_pulse),
        .o_level (key2_level)
    );

    key_debounce_channel #(
        .CNT_MAX (CNT_MAX),
        .CNT_W   (CNT_W)
    ) u_key0 (
        .clk     (clk),
        .rst     (rst),
        .i_key_n (key0_n),
        .o_pulse (key0_pulse),
        .o_level (key0_level)
    );

endmodule

// File: tb/tb_key_debounce_pulse.sv
//-----------------------------------------------------------------------------
// tb_key_debounce_pulse
//
// Directed bench for key_debounce_pulse with CNT_MAX = 4. Inputs change 1 ns
// after a rising edge, so the next rising edge is the first to sample them
// (edge 0). After n calls of tick(1) the outputs reflect edge n-1; a press
// therefore shows its pulse after 7 ticks (edge CNT_MAX+2 = 6).
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_key_debounce_pulse;

    localparam int CNT_MAX = 4;
    localparam int CNT_W   = 3;

    logic clk = 1'b0;
    logic rst;
    logic key2_n;
    logic key0_n;
    logic key2_pulse;
    logic key0_pulse;
    logic key2_level;
    logic key0_level;

    int n_checks = 0;
    int n_errors = 0;

    // Running pulse tallies and a 2-bit model of the downstream counter.
    int       p0_total = 0;
    int       p2_total = 0;
    logic [1:0] dn_cnt = 2'd0;

    int b0;
    int b2;
    logic [1:0] exp_seq [4];

    key_debounce_pulse #(
        .CNT_MAX (CNT_MAX),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key2_n     (key2_n),
        .key0_n     (key0_n),
        .key2_pulse (key2_pulse),
        .key0_pulse (key0_pulse),
        .key2_level (key2_level),
        .key0_level (key0_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (key0_pulse) p0_total <= p0_total + 1;
        if (key2_pulse) p2_total <= p2_total + 1;
        if (rst)             dn_cnt <= 2'd0;
        else if (key0_pulse) dn_cnt <= dn_cnt + 2'd1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        exp_seq[0] = 2'd1;
        exp_seq[1] = 2'd2;
        exp_seq[2] = 2'd3;
        exp_seq[3] = 2'd0;

        // ---- Reset ----
        rst = 1'b1; key2_n = 1'b1; key0_n = 1'b1;
        tick(2);
        check("rst_p0", key0_pulse, 0);
        check("rst_p2", key2_pulse, 0);
        check("rst_l0", key0_level, 0);
        check("rst_l2", key2_level, 0);
        rst = 1'b0;
        tick(2);

        // ---- Clean press on KEY0, held 20 cycles, then released ----
        b0 = p0_total;
        key0_n = 1'b0;
        tick(6);
        check("clean_p0_e5", key0_pulse, 0);
        check("clean_l0_e5", key0_level, 0);
        tick(1);
        check("clean_p0_e6", key0_pulse, 1);
        check("clean_l0_e6", key0_level, 1);
        check("clean_p2_e6", key2_pulse, 0);
        check("clean_l2_e6", key2_level, 0);
        tick(1);
        check("clean_p0_e7", key0_pulse, 0);
        check("clean_l0_e7", key0_level, 1);
        tick(12);
        check("clean_cnt_held", p0_total - b0, 1);
        check("clean_l2_held", key2_level, 0);
        key0_n = 1'b1;
        tick(6);
        check("rel_l0_e5", key0_level, 1);
        tick(1);
        check("rel_l0_e6", key0_level, 0);
        check("rel_p0_e6", key0_pulse, 0);
        tick(5);
        check("rel_no_pulse", p0_total - b0, 1);

        // ---- Bounce 0,1,0,0,1 on KEY2: rejected ----
        b2 = p2_total;
        key2_n = 1'b0; tick(1);
        key2_n = 1'b1; tick(1);
        key2_n = 1'b0; tick(2);
        key2_n = 1'b1;
        tick(15);
        check("bounce_l2", key2_level, 0);
        check("bounce_cnt", p2_total - b2, 0);

        // ---- Bounce 0,1,0 then stable 0: one pulse 6 edges after last 1->0 ----
        key2_n = 1'b0; tick(1);
        key2_n = 1'b1; tick(1);
        key2_n = 1'b0;
        tick(6);
        check("bounce2_p2_e5", key2_pulse, 0);
        tick(1);
        check("bounce2_p2_e6", key2_pulse, 1);
        check("bounce2_l2_e6", key2_level, 1);
        tick(1);
        check("bounce2_p2_e7", key2_pulse, 0);
        tick(5);
        check("bounce2_cnt", p2_total - b2, 1);
        key2_n = 1'b1;
        tick(10);
        check("bounce2_rel_l2", key2_level, 0);

        // ---- Hold 50 cycles, 2-cycle release glitch, then real release ----
        b0 = p0_total;
        key0_n = 1'b0;
        tick(50);
        check("hold_l0", key0_level, 1);
        check("hold_cnt", p0_total - b0, 1);
        key0_n = 1'b1; tick(2);
        key0_n = 1'b0;
        tick(20);
        check("glitch_l0", key0_level, 1);
        check("glitch_cnt", p0_total - b0, 1);
        key0_n = 1'b1;
        tick(6);
        check("hold_rel_l0_e5", key0_level, 1);
        tick(1);
        check("hold_rel_l0_e6", key0_level, 0);
        tick(5);
        check("hold_rel_cnt", p0_total - b0, 1);

        // ---- Four presses: downstream counter reads 1,2,3,0 ----
        rst = 1'b1; tick(2);
        rst = 1'b0; tick(2);
        b0 = p0_total;
        for (int i = 0; i < 4; i++) begin
            key0_n = 1'b0; tick(10);
            key0_n = 1'b1; tick(10);
            check($sformatf("repeat_dn_%0d", i), dn_cnt, exp_seq[i]);
        end
        check("repeat_cnt", p0_total - b0, 4);

        // ---- Simultaneous presses ----
        key2_n = 1'b0; key0_n = 1'b0;
        tick(6);
        check("simul_e5", {key2_pulse, key0_pulse}, 2'b00);
        tick(1);
        check("simul_p2_e6", key2_pulse, 1);
        check("simul_p0_e6", key0_pulse, 1);
        tick(1);
        check("simul_e7", {key2_pulse, key0_pulse}, 2'b00);
        key2_n = 1'b1; key0_n = 1'b1;
        tick(10);
        check("simul_rel", {key2_level, key0_level}, 2'b00);

        // ---- Reset in PRESS_WAIT (cnt=2), button kept pressed ----
        key0_n = 1'b0;
        tick(5);
        rst = 1'b1;
        tick(1);
        check("mid_rst_outs", {key2_pulse, key0_pulse, key2_level, key0_level}, 4'b0000);
        tick(1);
        rst = 1'b0;
        tick(6);
        check("post_rst_p0_e5", key0_pulse, 0);
        tick(1);
        check("post_rst_p0_e6", key0_pulse, 1);
        check("post_rst_l0_e6", key0_level, 1);
        tick(1);
        check("post_rst_p0_e7", key0_pulse, 0);

        // ---- Reset while HELD clears the level ----
        rst = 1'b1;
        tick(1);
        check("held_rst_l0", key0_level, 0);
        check("held_rst_p0", key0_pulse, 0);
        key0_n = 1'b1;
        rst = 1'b0;
        b0 = p0_total;
        tick(10);
        check("held_rst_quiet", p0_total - b0, 0);
        check("held_rst_l0_idle", key0_level, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/key_debounce_pulse.md
Name: key_debounce_pulse

Overview:
- Upstream conditioning stage for the push-button counter logic.
- Takes the two raw, asynchronous, active-low board buttons (KEY2, KEY0) and synchronises each to clk. Debounces each one and emits exactly one single-cycle press pulse per physical press.
- The pulses drive the downstream counter's Key_2/Key_0 inputs directly. A held button therefore counts once, not once per clock.
- The two channels are identical and fully independent.

Parameters:
- CNT_MAX, 1000000, number of consecutive stable synchronised samples required to accept a press or a release (20 ms at 50 MHz). Legal range 2..2^CNT_W-1.
- CNT_W, 20, width of each debounce counter. Must satisfy CNT_MAX-1 < 2^CNT_W.

Ports:
- clk  input  1  system clock. All logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- key2_n  input  1  raw KEY2 button, active low (0 = pressed), asynchronous to clk.
- key0_n  input  1  raw KEY0 button, active low (0 = pressed), asynchronous to clk.
- key2_pulse  output  1  one-cycle high pulse on each debounced KEY2 press. Drives downstream Key_2.
- key0_pulse  output  1  one-cycle high pulse on each debounced KEY0 press. Drives downstream Key_0.
- key2_level  output  1  debounced KEY2 state, 1 = held.
- key0_level  output  1  debounced KEY0 state, 1 = held.

Behaviour:
- The per-channel description below applies identically to KEY2 and KEY0. All outputs are registered.
- Synchroniser:
  - Two flip-flop chain per channel; the raw input is used nowhere else.
  - The signal s is the second flip-flop output, inverted so that 1 = pressed.
  - Both flip-flops reset to 1 (released).
- State machine per channel, with states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT:
  - IDLE: if s=1, go to PRESS_WAIT and set cnt to 0.
  - PRESS_WAIT:
    - if s=0, return to IDLE (bounce rejected; cnt is irrelevant);
    - else if cnt = CNT_MAX-1, go to HELD, set pulse to 1 and level to 1;
    - else increment cnt.
  - HELD: if s=0, go to RELEASE_WAIT and set cnt to 0. The pulse returns to 0 on the first cycle in HELD.
  - RELEASE_WAIT:
    - if s=1, return to HELD (no new pulse);
    - else if cnt = CNT_MAX-1, go to IDLE and set level to 0;
    - else increment cnt.
- Pulse rule: pulse is high for exactly one clock, and only on the PRESS_WAIT to HELD transition. It never fires on release and never repeats while held.
- Latency: number the first rising edge that samples key_n = 0 as edge 0, with the input stable afterwards.
  - s = 1 after edge 1.
  - PRESS_WAIT is entered at edge 2.
  - pulse and level go high after edge CNT_MAX+2; pulse goes low after edge CNT_MAX+3.
  - A release takes the same path: level goes low after edge CNT_MAX+2, counted from the first sampled 1.
- Glitch rejection: any single opposite sample during PRESS_WAIT or RELEASE_WAIT aborts the wait. The count restarts from 0 on the next qualifying entry.
- Counter: cnt never exceeds CNT_MAX-1 and never wraps.
- Reset (any cycle, including mid-debounce):
  - state = IDLE, cnt = 0, pulse = 0, level = 0;
  - synchroniser flip-flops = 1.
  - After rst deasserts with the button still held, this is treated as a fresh press: one pulse after the full latency.
- Simultaneous presses: each channel pulses independently. Both pulses may be high in the same cycle; priority is resolved downstream.

Test Plan:
(All scenarios use CNT_MAX=4.)
- Clean press: rst for 2 cycles, then key0_n goes to 0 and holds for 20 cycles -> key0_pulse high for exactly one cycle after edge 6 and key0_level = 1 from then. key2 outputs stay 0.
- Bounce rejection: key2_n follows the sequence 0,1,0,0,1 on consecutive edges, then returns to 1 -> key2_pulse and key2_level never assert. Separately, a sequence of 0,1,0 followed by stable 0 -> exactly one pulse, 6 edges after the last 1-to-0 sample.
- Hold and release: key0_n = 0 for 50 cycles, then 1 -> exactly one key0_pulse. key0_level goes to 0 six edges after the first sampled 1. A 2-cycle release glitch during HELD -> no second pulse.
- Repeated presses: four clean KEY0 presses separated by 10-cycle releases -> four pulses, and the downstream counter sequence reads 1,2,3,0.
- Simultaneous presses: key2_n and key0_n both go to 0 on the same edge -> key2_pulse and key0_pulse are both high in the same cycle (after edge 6).
- Reset mid-operation: assert rst while in PRESS_WAIT with cnt=2 -> all outputs 0 on the next edge. After rst deasserts with key0_n still 0 -> one pulse 6 edges after the first post-reset sampling edge.
